spi_slave_xfer: RTL

SPI target-side transfer engine. It consumes the bus driven by the SPI master controller (sck, nss, mosi) and returns miso, so it sits directly downstream of the master. It is used as an on-chip loopback/peer for SoC bring-up and as a standalone slave port. Bus inputs are oversampled in the clk_i domain, words are deserialised onto an RX valid/ready port, and the TX word is serialised from a valid/ready port.

---
 rtl/spi_slave_xfer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_xfer.sv
// SPI target-side transfer engine: oversamples sck/nss/mosi in clk_i, deserialises RX words
// onto a valid/ready port and serialises TX words from a valid/ready port onto miso.
module spi_slave_xfer #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_i,
  input  logic [1:0]            dtb_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic                  unf_o
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, nss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, nss_prev_q;
  logic                   sck_s, nss_s, mosi_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign nss_s  = nss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q  <= '0;
      nss_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      nss_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_s;
      nss_prev_q  <= nss_s;
    end
  end

  logic                  cpol_q, cpha_q, lsb_q;
  logic [1:0]            dtb_q;
  logic                  cpol_d, cpha_d, lsb_d;
  logic [1:0]            dtb_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  ovf_q, ovf_d;

  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge, nss_fall;
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign lead_edge   = cpol_q ? sck_fall : sck_rise;
  assign trail_edge  = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign nss_fall    = nss_prev_q & ~nss_s;

  logic [CNT_W-1:0]      n_bits;
  logic [IDX_W-1:0]      n_m1_q, n_m1_i;
  logic [DATA_WIDTH-1:0] load_word, tx_next, rx_lsb_ins, rx_mask;

  assign n_bits    = CNT_W'({dtb_q, 3'b000}) + CNT_W'(8);
  assign n_m1_q    = IDX_W'({dtb_q, 3'b111});
  assign n_m1_i    = IDX_W'({dtb_i, 3'b111});
  assign load_word = tx_valid_i ? tx_data_i : '0;
  assign tx_next   = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  assign rx_mask   = {DATA_WIDTH{1'b1}} >> (CNT_W'(DATA_WIDTH) - n_bits);

  always_comb begin
    rx_lsb_ins         = rx_sr_q >> 1;
    rx_lsb_ins[n_m1_q] = mosi_s;
  end

  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    dtb_d   = dtb_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (nss_fall) state_d = LOAD;
      end
      LOAD: begin
        if (nss_s) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          lsb_d   = lsb_i;
          dtb_d   = dtb_i;
          tx_sr_d = load_word;
          rx_sr_d = '0;
          cnt_d   = '0;
          miso_d  = lsb_i ? load_word[0] : load_word[n_m1_i];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (nss_s) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sample_edge) begin
          rx_sr_d = lsb_q ? rx_lsb_ins : {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1)) == n_bits) state_d = DONE;
        end else if (shift_edge && (cnt_q != '0)) begin
          // A shift edge before the first sample is either the cpha=1 leading edge or the
          // cpha=0 trailing edge left over from the previous word; LOAD already drove bit 0.
          tx_sr_d = tx_next;
          miso_d  = lsb_q ? tx_next[0] : tx_next[n_m1_q];
        end
      end
      DONE: begin
        if (nss_s) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RX port: rx_data_o is stable while rx_valid_o is high; a word is consumed on any clk_i
  // edge with rx_valid_o && rx_ready_i. TX port: tx_ready_o pulses in the cycle tx_data_i is taken.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    ovf_d      = 1'b0;
    if (state_q == DONE) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_sr_q & rx_mask;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      dtb_q      <= 2'b00;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      dtb_q      <= dtb_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign spi_miso_o = miso_q;
  assign tx_ready_o = (state_q == LOAD) && tx_valid_i;
  assign unf_o      = (state_q == LOAD) && !tx_valid_i;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign busy_o     = (state_q != IDLE);
  assign ovf_o      = ovf_q;

endmodule
